// File: rtl/pkt_pkg.sv
// pkt_pkg: shared widths, handshake state type and word-select helper for
// the 47-bit packet receive channel.
package pkt_pkg;

  localparam int unsigned PKT_DWIDTH = 8;
  localparam int unsigned PKT_NWORDS = 5;
  localparam int unsigned PKT_PWIDTH = 47;
  localparam int unsigned PKT_HWIDTH = PKT_PWIDTH - PKT_NWORDS * PKT_DWIDTH;
  localparam int unsigned PKT_IDXW   = $clog2(PKT_NWORDS);

  typedef enum logic [0:0] {
    HS_IDLE = 1'b0,
    HS_ACK  = 1'b1
  } hs_state_t;

  // Select data word idx (word 0 = least significant) of a default-width packet.
  function automatic logic [PKT_DWIDTH-1:0] word_of(input logic [PKT_PWIDTH-1:0] pkt,
                                                    input logic [PKT_IDXW-1:0]   idx);
    logic [PKT_DWIDTH-1:0] w;
    w = '0;
    for (int unsigned i = 0; i < PKT_NWORDS; i++) begin
      if (idx == PKT_IDXW'(i)) w = pkt[i*PKT_DWIDTH +: PKT_DWIDTH];
    end
    return w;
  endfunction

endpackage

// File: rtl/pkt_req_sync.sv
// pkt_req_sync: STAGES-deep flop chain bringing the asynchronous request
// into the clk domain. Synchronous active-high reset clears every stage.
module pkt_req_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the raw request through the synchronizer chain.
  always_ff @(posedge clk) begin
    if (reset) chain <= '0;
    else       chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/pkt_rx_unpack.sv
// pkt_rx_unpack: four-phase packet receiver with a one-packet buffer that
// streams NWORDS data words (low word first) plus the header on valid/ready.
// Optional statistics ports are built when PKT_STATS_EN is defined.
module pkt_rx_unpack
  import pkt_pkg::*;
#(
  parameter  int unsigned DWIDTH      = PKT_DWIDTH,
  parameter  int unsigned NWORDS      = PKT_NWORDS,
  parameter  int unsigned PWIDTH      = PKT_PWIDTH,
  parameter  int unsigned SYNC_STAGES = 2,
  localparam int unsigned HWIDTH      = PWIDTH - NWORDS * DWIDTH,
  localparam int unsigned IDXW        = $clog2(NWORDS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic [PWIDTH-1:0] packet,
  output logic              ack,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_data,
  output logic [HWIDTH-1:0] out_hdr,
  output logic [IDXW-1:0]   out_idx,
  output logic              out_last
`ifdef PKT_STATS_EN
  ,
  output logic [31:0]       pkt_count,
  output logic [DWIDTH+2:0] last_sum
`endif
);

  logic              req_s;
  hs_state_t         hs_state;
  logic              full;
  logic [IDXW-1:0]   idx;
  logic [PWIDTH-1:0] buf_pkt;
  logic              pop;
  logic              at_last;
  logic              can_accept;
  logic              capture;

  pkt_req_sync #(.STAGES(SYNC_STAGES)) u_req_sync (
    .clk   (clk),
    .reset (reset),
    .d     (req),
    .q     (req_s)
  );

  assign pop        = full & out_ready;
  assign at_last    = (idx == IDXW'(NWORDS - 1));
  // A final-word pop frees the buffer in the same cycle, so a waiting
  // packet can be captured without a bubble on out_valid.
  assign can_accept = ~full | (pop & at_last);
  assign capture    = (hs_state == HS_IDLE) & req_s & can_accept;

  // Four-phase handshake: raise ack on capture, drop it once req_s returns low.
  always_ff @(posedge clk) begin
    if (reset) begin
      hs_state <= HS_IDLE;
      ack      <= 1'b0;
    end else begin
      case (hs_state)
        HS_IDLE: if (capture) begin
          hs_state <= HS_ACK;
          ack      <= 1'b1;
        end
        HS_ACK: if (!req_s) begin
          hs_state <= HS_IDLE;
          ack      <= 1'b0;
        end
        default: begin
          hs_state <= HS_IDLE;
          ack      <= 1'b0;
        end
      endcase
    end
  end

  // One-packet buffer and word index; capture has priority over a final pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      full    <= 1'b0;
      idx     <= '0;
      buf_pkt <= '0;
    end else if (capture) begin
      full    <= 1'b1;
      idx     <= '0;
      buf_pkt <= packet;
    end else if (pop) begin
      if (at_last) begin
        full <= 1'b0;
        idx  <= '0;
      end else begin
        idx <= idx + IDXW'(1);
      end
    end
  end

  // Present the current word and header straight from the buffer.
  always_comb begin
    out_data = '0;
    for (int unsigned i = 0; i < NWORDS; i++) begin
      if (idx == IDXW'(i)) out_data = buf_pkt[i*DWIDTH +: DWIDTH];
    end
  end

  assign out_valid = full;
  assign out_idx   = idx;
  assign out_last  = at_last;
  assign out_hdr   = buf_pkt[PWIDTH-1 -: HWIDTH];

`ifdef PKT_STATS_EN
  logic [DWIDTH+2:0] sum_in;

  // Zero-extended sum of the incoming packet's data words.
  always_comb begin
    sum_in = '0;
    for (int unsigned i = 0; i < NWORDS; i++) begin
      sum_in = sum_in + (DWIDTH+3)'(packet[i*DWIDTH +: DWIDTH]);
    end
  end

  // Capture statistics, updated on the same edge that loads the buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_count <= '0;
      last_sum  <= '0;
    end else if (capture) begin
      pkt_count <= pkt_count + 32'd1;
      last_sum  <= sum_in;
    end
  end
`endif

endmodule

// File: tb/tb_pkt_rx_unpack.sv
// tb_pkt_rx_unpack: randomized self-checking bench. The reference model is a
// queue of expected words built arithmetically from every packet offered.
module tb_pkt_rx_unpack;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic [46:0] packet;
  logic        ack;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [6:0]  out_hdr;
  logic [2:0]  out_idx;
  logic        out_last;
`ifdef PKT_STATS_EN
  logic [31:0] pkt_count;
  logic [10:0] last_sum;
`endif

  pkt_rx_unpack dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .packet    (packet),
    .ack       (ack),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_hdr   (out_hdr),
    .out_idx   (out_idx),
    .out_last  (out_last)
`ifdef PKT_STATS_EN
    ,
    .pkt_count (pkt_count),
    .last_sum  (last_sum)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [6:0] hdr;
    logic [2:0] idx;
    logic       last;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   pops     = 0;
  int   ready_mode = 0; // 0: always 1, 1: random, 2: 1,0,0 pattern, 3: always 0

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Expected stream for one packet: word k is bits [8k+7:8k], header on top.
  task automatic push_pkt(input logic [46:0] p);
    exp_t        e;
    logic [46:0] t;
    for (int k = 0; k < 5; k++) begin
      t      = p >> (8 * k);
      e.data = t[7:0];
      e.hdr  = p[46:40];
      e.idx  = 3'(k);
      e.last = (k == 4);
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_ack(input logic lvl, input string tag, output int cyc);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (ack !== lvl && cyc < 400);
    if (ack !== lvl) check({tag, "_timeout"}, 64'(ack), 64'(lvl));
  endtask

  task automatic send_pkt(input logic [46:0] p);
    int c;
    push_pkt(p);
    packet = p;
    req    = 1'b1;
    wait_ack(1'b1, "send_ack_rise", c);
    req = 1'b0;
    wait_ack(1'b0, "send_ack_fall", c);
  endtask

  task automatic drain();
    int c = 0;
    while ((exp_q.size() != 0 || out_valid) && c < 1000) begin
      @(posedge clk); #1;
      c++;
    end
    check("drain_done", 64'(exp_q.size()), 64'd0);
  endtask

  // Downstream ready generator.
  initial begin
    int pat = 0;
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        2:       out_ready = (pat % 3 == 0);
        default: out_ready = 1'b0;
      endcase
      pat++;
    end
  end

  // Stream monitor: every pop must match the model; stalled words must hold.
  initial begin
    logic       hold = 1'b0;
    logic [7:0] p_data;
    logic [6:0] p_hdr;
    logic [2:0] p_idx;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (reset) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          check("hold_valid", 64'(out_valid), 64'd1);
          check("hold_data", 64'(out_data), 64'(p_data));
          check("hold_hdr", 64'(out_hdr), 64'(p_hdr));
          check("hold_idx", 64'(out_idx), 64'(p_idx));
        end
        hold = 1'b0;
        if (out_valid) begin
          if (out_ready) begin
            if (exp_q.size() == 0) begin
              check("extra_pop", 64'd1, 64'd0);
            end else begin
              e = exp_q.pop_front();
              check("pop_data", 64'(out_data), 64'(e.data));
              check("pop_hdr", 64'(out_hdr), 64'(e.hdr));
              check("pop_idx", 64'(out_idx), 64'(e.idx));
              check("pop_last", 64'(out_last), 64'(e.last));
            end
            pops++;
          end else begin
            hold   = 1'b1;
            p_data = out_data;
            p_hdr  = out_hdr;
            p_idx  = out_idx;
          end
        end
      end
    end
  end

  initial begin
    int          c;
    int          base;
    int          gaps;
    logic        ack_seen;
    logic [46:0] p;

    reset = 1'b1; req = 1'b0; packet = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", 64'(ack), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    check("rst_hdr", 64'(out_hdr), 64'd0);
    check("rst_idx", 64'(out_idx), 64'd0);
    check("rst_last", 64'(out_last), 64'd0);
`ifdef PKT_STATS_EN
    check("rst_count", 64'(pkt_count), 64'd0);
    check("rst_sum", 64'(last_sum), 64'd0);
`endif
    reset = 1'b0;
    @(posedge clk); #1;

    // Single directed packet at full ready, with handshake latencies.
    ready_mode = 0;
    p = 47'h55_0403020100;
    push_pkt(p);
    packet = p; req = 1'b1;
    wait_ack(1'b1, "t1_ack_rise", c);
    check("t1_rise_lat", 64'(c), 64'd3);
    check("t1_valid_with_ack", 64'(out_valid), 64'd1);
    check("t1_first_idx", 64'(out_idx), 64'd0);
    req = 1'b0;
    wait_ack(1'b0, "t1_ack_fall", c);
    check("t1_fall_lat", 64'(c), 64'd3);
    drain();
    check("t1_pops", 64'(pops), 64'd5);

    // Stalling consumer 1,0,0 pattern.
    ready_mode = 2;
    base = pops;
    send_pkt({$urandom, $urandom});
    drain();
    check("t2_pops", 64'(pops - base), 64'd5);

    // Backpressure: second request blocked for 50 cycles, then no bubble.
    ready_mode = 3;
    repeat (2) @(posedge clk);
    #1;
    base = pops;
    send_pkt({$urandom, $urandom});
    p = {$urandom, $urandom};
    push_pkt(p);
    packet = p; req = 1'b1;
    ack_seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (ack) ack_seen = 1'b1;
    end
    check("t3_ack_blocked", 64'(ack_seen), 64'd0);
    check("t3_held_idx", 64'(out_idx), 64'd0);
    ready_mode = 0;
    gaps = 0; c = 0;
    while (pops < base + 10 && c < 80) begin
      @(negedge clk); #1;
      c++;
      if (!out_valid) gaps++;
    end
    check("t3_pops", 64'(pops - base), 64'd10);
    check("t3_bubbles", 64'(gaps), 64'd0);
    check("t3_ack_after_pop", 64'(ack), 64'd1);
    req = 1'b0;
    wait_ack(1'b0, "t3_ack_fall", c);
    drain();

    // Randomized packets against random ready.
    ready_mode = 1;
    base = pops;
    for (int n = 0; n < 8; n++) send_pkt({$urandom, $urandom});
    drain();
    check("t4_pops", 64'(pops - base), 64'd40);

    // Reset at idx 2 while req is still high; packet is recaptured.
    ready_mode = 0;
    p = {$urandom, $urandom};
    push_pkt(p);
    packet = p; req = 1'b1;
    c = 0;
    while (!(out_valid && out_idx == 3'd2) && c < 100) begin
      @(posedge clk); #1;
      c++;
    end
    check("t5_reach_idx2", 64'(out_idx), 64'd2);
    reset = 1'b1;
    @(posedge clk); #1;
    check("t5_rst_valid", 64'(out_valid), 64'd0);
    check("t5_rst_ack", 64'(ack), 64'd0);
    check("t5_rst_idx", 64'(out_idx), 64'd0);
    check("t5_rst_data", 64'(out_data), 64'd0);
    check("t5_rst_hdr", 64'(out_hdr), 64'd0);
    exp_q.delete();
    push_pkt(p);
    base = pops;
    reset = 1'b0;
    wait_ack(1'b1, "t5_recap", c);
    check("t5_recap_idx", 64'(out_idx), 64'd0);
    req = 1'b0;
    wait_ack(1'b0, "t5_fall", c);
    drain();
    check("t5_pops", 64'(pops - base), 64'd5);

`ifdef PKT_STATS_EN
    // Statistics over three all-0xFF packets.
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    for (int n = 0; n < 3; n++) send_pkt({7'($urandom), 40'hFF_FFFF_FFFF});
    drain();
    check("stats_count", 64'(pkt_count), 64'd3);
    check("stats_sum", 64'(last_sum), 64'h4FB);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
